// File: rtl/bus_console.sv
// Bus-mapped console: 16-byte register window feeding a TX byte FIFO.
// Define CONSOLE_IRQ_EN to add the registered empty interrupt and CTRL[1].
module bus_console #(
  parameter logic [31:0] BASE_ADDR = 32'h8000_0000,
  parameter int          DEPTH     = 16,
  parameter int          AW        = 4
) (
  input  logic        clk,
  input  logic        Nrst,
  input  logic [31:0] bus_addr,
  input  logic        bus_rd,
  input  logic        bus_wr,
  input  logic [31:0] bus_wdata,
  output logic [31:0] bus_rdata,
  output logic        bus_ready,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
`ifdef CONSOLE_IRQ_EN
  output logic        irq,
`endif
  input  logic        tx_ready
);

  typedef enum logic [1:0] {
    IDLE,
    ACK,
    HOLD
  } state_e;

  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [1:0]  OFF_DATA = 2'd0;
  localparam logic [1:0]  OFF_STAT = 2'd1;
  localparam logic [1:0]  OFF_CTRL = 2'd2;

  state_e        state_q, state_d;
  logic [1:0]    off_q, off_d;
  logic          wr_q, wr_d;
  logic [7:0]    wdata_q, wdata_d;
  logic          en_q, en_d;
  logic [AW:0]   count_q, count_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [7:0]    mem [DEPTH];

  logic          irq_en;
  logic          sel, empty, full;
  logic          pop, push;
  logic          data_wr, ctrl_wr;
  logic          in_ack, stall, done;
  logic [8:0]    cnt9;
  logic [31:0]   rd_val;
  logic          unused;

  assign sel = (bus_addr[31:4] == BASE_ADDR[31:4])
             & (bus_rd | bus_wr);

  assign empty    = (count_q == '0);
  assign full     = (count_q == FULL_CNT);
  assign tx_valid = en_q & ~empty;
  assign tx_data  = empty ? 8'h00 : mem[rd_ptr_q];
  assign pop      = tx_valid & tx_ready;

  assign data_wr = wr_q & (off_q == OFF_DATA);
  assign ctrl_wr = wr_q & (off_q == OFF_CTRL);
  assign in_ack  = (state_q == ACK);
  // A full FIFO only takes the byte if a slot drains this same cycle
  assign stall   = data_wr & full & ~pop;
  assign done    = in_ack & ~stall;
  assign push    = done & data_wr;

  assign cnt9 = 9'(count_q);

  always_comb begin
    rd_val = '0;
    unique case (1'b1)
      off_q == OFF_STAT:
        rd_val = {16'h0, cnt9[7:0], 6'h0, empty, full};
      off_q == OFF_CTRL:
        rd_val = {30'h0, irq_en, en_q};
      default:
        rd_val = '0;
    endcase
  end

  assign bus_ready = done;
  assign bus_rdata = (done & ~wr_q) ? rd_val : '0;

  always_comb begin
    state_d  = state_q;
    off_d    = off_q;
    wr_d     = wr_q;
    wdata_d  = wdata_q;
    en_d     = en_q;
    unique case (state_q)
      IDLE: begin
        if (sel) begin
          off_d   = bus_addr[3:2];
          wr_d    = ~bus_rd;
          wdata_d = bus_wdata[7:0];
          state_d = ACK;
        end
      end
      ACK: begin
        if (done) begin
          state_d = HOLD;
          if (ctrl_wr) en_d = wdata_q[0];
        end
      end
      HOLD: begin
        if (~bus_rd & ~bus_wr) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    count_d  = count_q + (AW+1)'(push) - (AW+1)'(pop);
    wr_ptr_d = wr_ptr_q + AW'(push);
    rd_ptr_d = rd_ptr_q + AW'(pop);
  end

  always_ff @(posedge clk or negedge Nrst) begin
    if (!Nrst) begin
      state_q  <= IDLE;
      off_q    <= '0;
      wr_q     <= 1'b0;
      wdata_q  <= '0;
      en_q     <= 1'b0;
      count_q  <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      off_q    <= off_d;
      wr_q     <= wr_d;
      wdata_q  <= wdata_d;
      en_q     <= en_d;
      count_q  <= count_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= wdata_q;
  end

`ifdef CONSOLE_IRQ_EN
  logic irq_en_q, irq_en_d;
  logic irq_q, irq_d;

  always_comb begin
    irq_en_d = irq_en_q;
    if (done & ctrl_wr) irq_en_d = wdata_q[1];
    irq_d = irq_en_q & empty;
  end

  always_ff @(posedge clk or negedge Nrst) begin
    if (!Nrst) begin
      irq_en_q <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      irq_en_q <= irq_en_d;
      irq_q    <= irq_d;
    end
  end

  assign irq_en = irq_en_q;
  assign irq    = irq_q;
`else
  assign irq_en = 1'b0;
`endif

  assign unused = ^{bus_wdata[31:8], bus_addr[1:0], cnt9[8]};

endmodule

// File: tb/tb_bus_console.sv
// Bench for bus_console: queue-based console model checked every cycle
// plus directed literal expectations.
module tb_bus_console;

  localparam logic [31:0] BASE  = 32'h8000_0000;
  localparam int          DEPTH = 16;
`ifdef CONSOLE_IRQ_EN
  localparam logic [31:0] CMASK = 32'h3;
`else
  localparam logic [31:0] CMASK = 32'h1;
`endif

  logic        clk = 1'b0;
  logic        Nrst;
  logic [31:0] bus_addr, bus_wdata, bus_rdata;
  logic        bus_rd, bus_wr, bus_ready;
  logic [7:0]  tx_data;
  logic        tx_valid, tx_ready;
  logic        irq;

  int checks   = 0;
  int failures = 0;

  bus_console dut (
    .clk       (clk),
    .Nrst      (Nrst),
    .bus_addr  (bus_addr),
    .bus_rd    (bus_rd),
    .bus_wr    (bus_wr),
    .bus_wdata (bus_wdata),
    .bus_rdata (bus_rdata),
    .bus_ready (bus_ready),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
`ifdef CONSOLE_IRQ_EN
    .irq       (irq),
`endif
    .tx_ready  (tx_ready)
  );

`ifndef CONSOLE_IRQ_EN
  assign irq = 1'b0;
`endif

  always #5 clk = ~clk;

  function automatic void chk(string n, logic [31:0] a, logic [31:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s act=%h exp=%h", n, a, e);
    end
  endfunction

  // Console model: byte queue, control word, transaction phase
  logic [7:0]  mq [$];
  logic [7:0]  plog [$];
  logic [31:0] m_ctrl;
  int          m_ph;
  logic [1:0]  m_off;
  logic        m_wr;
  logic [31:0] m_wd;
  logic        m_irq;

  function automatic logic [31:0] rval(logic [1:0] off, int sz);
    logic [7:0] c8;
    c8 = 8'(sz);
    case (off)
      2'd1: return {16'h0, c8, 6'h0, sz == 0, sz == DEPTH};
      2'd2: return m_ctrl;
      default: return 32'h0;
    endcase
  endfunction

  always @(negedge clk) begin
    logic        ev, erdy, pp, inext;
    logic [7:0]  ed;
    logic [31:0] er;
    if (!Nrst) begin
      chk("rst_ready", {31'h0, bus_ready}, 0);
      chk("rst_rdata", bus_rdata, 0);
      chk("rst_valid", {31'h0, tx_valid}, 0);
      chk("rst_data", {24'h0, tx_data}, 0);
      chk("rst_irq", {31'h0, irq}, 0);
      mq.delete();
      m_ctrl = 0;
      m_ph   = 0;
      m_irq  = 0;
    end else begin
      ev   = m_ctrl[0] && mq.size() > 0;
      ed   = mq.size() > 0 ? mq[0] : 8'h00;
      pp   = ev && tx_ready;
      erdy = 0;
      er   = 0;
      if (m_ph == 1 &&
          !(m_wr && m_off == 0 && mq.size() == DEPTH && !pp)) begin
        erdy = 1;
        if (!m_wr) er = rval(m_off, mq.size());
      end
      chk("m_ready", {31'h0, bus_ready}, {31'h0, erdy});
      chk("m_rdata", bus_rdata, er);
      chk("m_valid", {31'h0, tx_valid}, {31'h0, ev});
      chk("m_data", {24'h0, tx_data}, {24'h0, ed});
      chk("m_irq", {31'h0, irq}, {31'h0, m_irq});
      if (tx_valid && tx_ready) plog.push_back(tx_data);
      inext = m_ctrl[1] && mq.size() == 0;
      if (pp) void'(mq.pop_front());
      if (erdy) begin
        if (m_wr && m_off == 0) mq.push_back(m_wd[7:0]);
        if (m_wr && m_off == 2) m_ctrl = m_wd & CMASK;
        m_ph = 2;
      end else if (m_ph == 0 && (bus_rd || bus_wr) &&
                   bus_addr[31:4] == BASE[31:4]) begin
        m_off = bus_addr[3:2];
        m_wr  = !bus_rd;
        m_wd  = bus_wdata;
        m_ph  = 1;
      end else if (m_ph == 2 && !bus_rd && !bus_wr) begin
        m_ph = 0;
      end
      m_irq = inext;
    end
  end

  task automatic txn(input logic [31:0] a, input logic w,
                     input logic [31:0] d, output logic [31:0] rd,
                     output int lat, input int max);
    rd = '0;
    lat = -1;
    bus_addr  = a;
    bus_wr    = w;
    bus_rd    = !w;
    bus_wdata = d;
    for (int i = 0; i < max; i++) begin
      @(negedge clk);
      if (bus_ready) begin
        rd  = bus_rdata;
        lat = i;
        break;
      end
    end
    @(posedge clk); #1;
    bus_rd = 0;
    bus_wr = 0;
    @(posedge clk); #1;
  endtask

  initial begin
    #400000;
    $display("FAIL global_timeout act=running exp=finished");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end

  initial begin
    logic [31:0] rd;
    int lat, n;
    Nrst = 0; bus_addr = 0; bus_rd = 0; bus_wr = 0;
    bus_wdata = 0; tx_ready = 0;
    repeat (2) @(posedge clk);
    #1 Nrst = 1;
    @(posedge clk); #1;

    // 1: single push with drain disabled
    txn(BASE, 1, 32'h41, rd, lat, 20);
    chk("t1_lat", lat, 1);
    txn(BASE + 4, 0, 0, rd, lat, 20);
    chk("t1_stat", rd, 32'h0100);
    chk("t1_valid", {31'h0, tx_valid}, 0);

    // 2: enable drain, stream two bytes
    tx_ready = 1;
    txn(BASE + 8, 1, 32'h1, rd, lat, 20);
    chk("t2_ctrl_lat", lat, 1);
    txn(BASE, 1, 32'h48, rd, lat, 20);
    txn(BASE, 1, 32'h49, rd, lat, 20);
    repeat (3) @(posedge clk); #1;
    chk("t2_npop", plog.size(), 3);
    chk("t2_b0", {24'h0, plog[0]}, 32'h41);
    chk("t2_b1", {24'h0, plog[1]}, 32'h48);
    chk("t2_b2", {24'h0, plog[2]}, 32'h49);
    txn(BASE + 4, 0, 0, rd, lat, 20);
    chk("t2_stat", rd, 32'h0002);
    txn(BASE + 8, 0, 0, rd, lat, 20);
    chk("t2_ctrl_rd", rd, 32'h1);

    // 3: fill, 17th write waits until one byte drains
    tx_ready = 0;
    for (int i = 0; i < 16; i++)
      txn(BASE, 1, 32'h60 + i, rd, lat, 20);
    txn(BASE + 4, 0, 0, rd, lat, 20);
    chk("t3_stat_full", rd, 32'h1001);
    fork
      txn(BASE, 1, 32'h70, rd, lat, 40);
      begin
        repeat (5) @(posedge clk);
        #1 tx_ready = 1;
        @(posedge clk);
        #1 tx_ready = 0;
      end
    join
    chk("t3_wait_lat", lat, 5);
    tx_ready = 1;
    repeat (20) @(posedge clk); #1;
    tx_ready = 0;
    chk("t3_npop", plog.size(), 20);
    chk("t3_first", {24'h0, plog[3]}, 32'h60);
    chk("t3_last", {24'h0, plog[19]}, 32'h70);
    txn(BASE + 4, 0, 0, rd, lat, 20);
    chk("t3_stat_empty", rd, 32'h0002);

    // 4: reserved offset, DATA read, out-of-window
    txn(BASE + 32'hC, 0, 0, rd, lat, 20);
    chk("t4_rsv_lat", lat, 1);
    chk("t4_rsv_rd", rd, 0);
    txn(BASE + 32'hC, 1, 32'hFFFF_FFFF, rd, lat, 20);
    chk("t4_rsv_wlat", lat, 1);
    txn(BASE, 0, 0, rd, lat, 20);
    chk("t4_data_rd", rd, 0);
    txn(BASE + 32'h10, 0, 0, rd, lat, 8);
    chk("t4_unsel", lat, -1);

    // 5: long-held read acks once
    bus_addr = BASE + 4;
    bus_rd = 1;
    n = 0;
    repeat (5) begin
      @(negedge clk);
      if (bus_ready) n++;
    end
    @(posedge clk); #1 bus_rd = 0;
    repeat (2) @(posedge clk); #1;
    chk("t5_one_pulse", n, 1);

    // 5b: reset while a write is stalled on a full FIFO
    for (int i = 0; i < 16; i++)
      txn(BASE, 1, 32'h80 + i, rd, lat, 20);
    bus_addr = BASE; bus_wdata = 32'h99; bus_wr = 1;
    repeat (3) @(posedge clk); #1;
    chk("t5_pre_valid", {31'h0, tx_valid}, 1);
    chk("t5_pre_wait", {31'h0, bus_ready}, 0);
    Nrst = 0;
    bus_wr = 0;
    @(negedge clk);
    chk("t5_rst_valid", {31'h0, tx_valid}, 0);
    chk("t5_rst_data", {24'h0, tx_data}, 0);
    @(posedge clk); #1 Nrst = 1;
    @(posedge clk); #1;
    txn(BASE + 4, 0, 0, rd, lat, 20);
    chk("t5_stat", rd, 32'h0002);
    txn(BASE + 8, 0, 0, rd, lat, 20);
    chk("t5_ctrl", rd, 0);

    // 6: interrupt on empty
    txn(BASE + 8, 1, 32'h3, rd, lat, 20);
`ifdef CONSOLE_IRQ_EN
    @(negedge clk);
    chk("t6_irq_on", {31'h0, irq}, 1);
    @(posedge clk); #1;
    txn(BASE, 1, 32'h55, rd, lat, 20);
    @(negedge clk);
    chk("t6_irq_off", {31'h0, irq}, 0);
    @(posedge clk); #1;
    txn(BASE + 8, 0, 0, rd, lat, 20);
    chk("t6_ctrl", rd, 32'h3);
`else
    txn(BASE + 8, 0, 0, rd, lat, 20);
    chk("t6_ctrl", rd, 32'h1);
`endif
    tx_ready = 1;
    repeat (4) @(posedge clk); #1;
    tx_ready = 0;
    repeat (2) @(posedge clk); #1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
